// File: rtl/counter_enable_ctrl_pkg.sv
// Shared state encoding and default parameters for the counter enable controller.
package counter_enable_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_DEFAULT      = 4;
  localparam int TERMINAL_DEFAULT = 15;

endpackage

// File: rtl/edge_detect_rise.sv
// One-clock rising-edge detector for a level input; history cleared synchronously.
module edge_detect_rise (
  input  logic clk,
  input  logic clear,
  input  logic x,
  output logic rise
);

  logic x_d;

  always_ff @(posedge clk) begin
    if (clear) begin
      x_d <= 1'b0;
    end else begin
      x_d <= x;
    end
  end

  assign rise = x & ~x_d;

endmodule

// File: rtl/counter_enable_ctrl.sv
// Run/stop/step controller producing the enable and active-low clear of a downstream
// counter, with a DIV-clock prescaler and a programmable terminal value.
module counter_enable_ctrl
  import counter_enable_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIV      = DIV_DEFAULT,
  parameter int TERMINAL = TERMINAL_DEFAULT
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [WIDTH-1:0] q,
  output logic             enable,
  output logic             cnt_clear_n,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [7:0]       PRESC_LAST = 8'(DIV - 1);
  localparam logic [WIDTH-1:0] TERM_VAL   = WIDTH'(TERMINAL);

  logic       start_rise;
  logic       stop_rise;
  logic       step_rise;
  logic       at_term;
  logic [7:0] presc;
  state_t     st;

  edge_detect_rise u_start (.clk(clk), .clear(clear), .x(start), .rise(start_rise));
  edge_detect_rise u_stop  (.clk(clk), .clear(clear), .x(stop),  .rise(stop_rise));
  edge_detect_rise u_step  (.clk(clk), .clear(clear), .x(step),  .rise(step_rise));

  // enable is never high two cycles in a row, so q is already updated when compared here
  assign at_term = (q == TERM_VAL);
  assign state   = st;

  always_ff @(posedge clk) begin
    if (clear) begin
      st          <= IDLE;
      presc       <= '0;
      enable      <= 1'b0;
      cnt_clear_n <= 1'b0;
      done        <= 1'b0;
    end else begin
      enable      <= 1'b0;
      cnt_clear_n <= 1'b1;
      done        <= 1'b0;
      unique case (st)
        IDLE: begin
          if (!stop_rise) begin
            if (start_rise) begin
              st    <= RUN;
              presc <= '0;
            end else if (step_rise) begin
              st <= STEP;
            end
          end
        end
        RUN: begin
          if (stop_rise) begin
            st <= IDLE;
          end else if (presc == PRESC_LAST) begin
            presc <= '0;
            if (at_term) begin
              st   <= DONE;
              done <= 1'b1;
            end else begin
              enable <= 1'b1;
            end
          end else begin
            presc <= presc + 8'd1;
          end
        end
        STEP: begin
          if (stop_rise) begin
            st <= IDLE;
          end else if (at_term) begin
            st   <= DONE;
            done <= 1'b1;
          end else begin
            enable <= 1'b1;
            st     <= IDLE;
          end
        end
        DONE: begin
          if (stop_rise) begin
            st <= IDLE;
          end else if (start_rise) begin
            // restart from zero: clear the counter for one cycle while re-entering RUN
            cnt_clear_n <= 1'b0;
            presc       <= '0;
            st          <= RUN;
          end else begin
            done <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_enable_ctrl.sv
// Bench for counter_enable_ctrl: attached counter, behavioural reference model,
// per-cycle comparison, directed scenarios and a randomized phase.
module tb_counter_enable_ctrl;

  localparam int WIDTH    = 4;
  localparam int DIV      = 4;
  localparam int TERMINAL = 15;

  logic             clk = 1'b0;
  logic             clear = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             step = 1'b0;
  logic [WIDTH-1:0] q = '0;
  logic             enable;
  logic             cnt_clear_n;
  logic             done;
  logic [1:0]       state;

  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;

  int checks = 0;
  int failures = 0;

  counter_enable_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .TERMINAL(TERMINAL)) dut (
    .clk(clk), .clear(clear), .start(start), .stop(stop), .step(step), .q(q),
    .enable(enable), .cnt_clear_n(cnt_clear_n), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // downstream enable/clear counter, with a bench-only preload
  always @(posedge clk) begin
    if (load) q <= load_val;
    else if (cnt_clear_n === 1'b0) q <= '0;
    else if (enable === 1'b1) q <= q + 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: mode plus edges-since-run-entry, evaluated at each rising edge
  int  m_state = 0;
  int  m_en = 0;
  int  m_clrn = 0;
  int  m_done = 0;
  int  run_edges = 0;
  bit  h_start = 0, h_stop = 0, h_step = 0;
  bit  model_valid = 0;

  task automatic model_step();
    bit sr, pr, tr;
    sr = start && !h_start;
    pr = stop && !h_stop;
    tr = step && !h_step;
    if (clear) begin
      m_state = 0; m_en = 0; m_clrn = 0; m_done = 0; run_edges = 0;
      h_start = 0; h_stop = 0; h_step = 0;
      model_valid = 1;
    end else begin
      h_start = start; h_stop = stop; h_step = step;
      m_en = 0;
      m_clrn = 1;
      if (m_state == 0) begin
        if (pr) m_state = 0;
        else if (sr) begin m_state = 1; run_edges = 0; end
        else if (tr) m_state = 2;
      end else if (m_state == 1) begin
        if (pr) m_state = 0;
        else begin
          run_edges++;
          if (run_edges % DIV == 0) begin
            if (int'(q) == TERMINAL) m_state = 3;
            else m_en = 1;
          end
        end
      end else if (m_state == 2) begin
        if (pr) m_state = 0;
        else if (int'(q) == TERMINAL) m_state = 3;
        else begin m_en = 1; m_state = 0; end
      end else begin
        if (pr) m_state = 0;
        else if (sr) begin m_clrn = 0; run_edges = 0; m_state = 1; end
      end
      m_done = (m_state == 3) ? 1 : 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      chk("state", int'(state), m_state);
      chk("enable", int'(enable), m_en);
      chk("cnt_clear_n", int'(cnt_clear_n), m_clrn);
      chk("done", int'(done), m_done);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_q(input logic [WIDTH-1:0] v);
    load_val = v;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, second, n, cnt;

    // reset
    tick(2);
    chk("rst_state", int'(state), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_clear_n", int'(cnt_clear_n), 0);
    chk("rst_done", int'(done), 0);
    clear = 1'b0;
    tick(1);
    chk("clear_n_release", int'(cnt_clear_n), 1);

    // run pacing from q=0 to terminal
    load_q('0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("run_entry", int'(state), 1);
    first = -1;
    second = -1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (enable === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("first_enable_cycle", first, 4);
    chk("second_enable_cycle", second, 8);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk("done_reached", (n < 200) ? 1 : 0, 1);
    chk("done_q", int'(q), 15);
    chk("done_state", int'(state), 3);
    tick(3);
    chk("done_q_holds", int'(q), 15);

    // single step from q=5, step held high
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_to_idle", int'(state), 0);
    load_q(4'd5);
    step = 1'b1;
    cnt = 0;
    repeat (12) begin
      tick(1);
      if (enable === 1'b1) cnt++;
    end
    step = 1'b0;
    chk("step_pulses", cnt, 1);
    chk("step_q", int'(q), 6);
    chk("step_state", int'(state), 0);

    // step at terminal enters DONE, then restart from DONE
    load_q(4'd15);
    step = 1'b1;
    tick(2);
    step = 1'b0;
    chk("step_term_state", int'(state), 3);
    start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      start = 1'b0;
      if (cnt_clear_n === 1'b0) cnt++;
    end
    chk("restart_clear_cycles", cnt, 1);
    chk("restart_q", int'(q), 0);
    chk("restart_state", int'(state), 1);
    tick(20);
    chk("restart_q_progress", int'(q), 5);

    // priority: stop beats start in RUN, start beats step in IDLE
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    chk("prio_run_state", int'(state), 0);
    chk("prio_run_enable", int'(enable), 0);
    start = 1'b0;
    stop = 1'b0;
    tick(1);
    start = 1'b1;
    step = 1'b1;
    tick(1);
    chk("prio_idle_state", int'(state), 1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("prio_no_step_pulse", int'(enable), 0);
    end
    start = 1'b0;
    step = 1'b0;

    // reset mid-run at prescaler 2, q=7
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    load_q(4'd7);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    clear = 1'b1;
    tick(1);
    chk("midrst_enable", int'(enable), 0);
    chk("midrst_clear_n", int'(cnt_clear_n), 0);
    chk("midrst_state", int'(state), 0);
    clear = 1'b0;
    tick(1);
    chk("midrst_q", int'(q), 0);

    // randomized phase, checked every cycle by the model
    repeat (3000) begin
      @(negedge clk);
      clear = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) start = ~start;
      if ($urandom_range(0, 39) == 0) stop = ~stop;
      if ($urandom_range(0, 7) == 0) step = ~step;
      if ($urandom_range(0, 149) == 0) begin
        load_val = WIDTH'($urandom_range(0, 15));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
    clear = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
